// File: rtl/pipeline_layered_compositor.sv
// Layered compositor: background plus NUM_LAYERS foreground layers, one registered blend stage per layer.
// Define PIPELINE_FRAME_LATCH_EN to latch per-layer mode/opacity only at frame start.
module pipeline_layered_compositor #(
    parameter int R_WIDTH                        = 5,
    parameter int G_WIDTH                        = 6,
    parameter int B_WIDTH                        = 5,
    parameter logic [R_WIDTH-1:0] RED_PASS       = 5'b00100,
    parameter logic [G_WIDTH-1:0] GREEN_PASS     = 6'b101100,
    parameter logic [B_WIDTH-1:0] BLUE_PASS      = 5'b01100,
    parameter int PRECISION                      = 11,
    parameter int FETCH_DELAY                    = 3,
    parameter int NUM_LAYERS                     = 2,
    parameter int TRANSPARENCY_PRECISION         = 3
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic [PRECISION-1:0]                                  pixel_x,
    input  logic [PRECISION-1:0]                                  pixel_y,
    input  logic                                                  pixel_valid,
    input  logic [R_WIDTH+G_WIDTH+B_WIDTH-1:0]                    bg_pixel_in,
    input  logic [NUM_LAYERS*(R_WIDTH+G_WIDTH+B_WIDTH)-1:0]       fg_pixel_in,
    input  logic [NUM_LAYERS-1:0]                                 fg_pixel_skip,
    input  logic [2*NUM_LAYERS-1:0]                               ctrl_layer_mode,
    input  logic [(TRANSPARENCY_PRECISION+1)*NUM_LAYERS-1:0]      ctrl_layer_opacity,
    output logic [R_WIDTH+G_WIDTH+B_WIDTH-1:0]                    pixel_out,
    output logic [PRECISION-1:0]                                  pixel_x_out,
    output logic [PRECISION-1:0]                                  pixel_y_out,
    output logic                                                  pixel_valid_out
);

    localparam int PIXEL_SIZE = R_WIDTH + G_WIDTH + B_WIDTH;
    localparam int T          = TRANSPARENCY_PRECISION;
    localparam int OPW        = T + 1;
    localparam int RW         = R_WIDTH + T + 1;
    localparam int GW         = G_WIDTH + T + 1;
    localparam int BW         = B_WIDTH + T + 1;
    localparam logic [PIXEL_SIZE-1:0] KEY         = {RED_PASS, GREEN_PASS, BLUE_PASS};
    localparam logic [OPW-1:0]        OPACITY_ONE = OPW'(1 << T);

    // Per-channel (fg*op + acc*(2^T - op)) >> T; sums are wide enough that nothing overflows.
    function automatic logic [PIXEL_SIZE-1:0] blend_pixel(
        input logic [PIXEL_SIZE-1:0] fg,
        input logic [PIXEL_SIZE-1:0] acc,
        input logic [OPW-1:0]        op
    );
        logic [OPW-1:0]     inv;
        logic [RW-1:0]      r_sum;
        logic [GW-1:0]      g_sum;
        logic [BW-1:0]      b_sum;
        logic [R_WIDTH-1:0] r_res;
        logic [G_WIDTH-1:0] g_res;
        logic [B_WIDTH-1:0] b_res;
        inv   = OPACITY_ONE - op;
        r_sum = RW'(fg[PIXEL_SIZE-1 -: R_WIDTH]) * RW'(op)
              + RW'(acc[PIXEL_SIZE-1 -: R_WIDTH]) * RW'(inv);
        g_sum = GW'(fg[B_WIDTH +: G_WIDTH]) * GW'(op)
              + GW'(acc[B_WIDTH +: G_WIDTH]) * GW'(inv);
        b_sum = BW'(fg[0 +: B_WIDTH]) * BW'(op)
              + BW'(acc[0 +: B_WIDTH]) * BW'(inv);
        r_res = R_WIDTH'(r_sum >> T);
        g_res = G_WIDTH'(g_sum >> T);
        b_res = B_WIDTH'(b_sum >> T);
        return {r_res, g_res, b_res};
    endfunction

    logic [PIXEL_SIZE-1:0]     bg_dly [FETCH_DELAY];
    logic [PRECISION-1:0]      x_dly  [FETCH_DELAY];
    logic [PRECISION-1:0]      y_dly  [FETCH_DELAY];
    logic [FETCH_DELAY-1:0]    valid_dly;

    logic [2*NUM_LAYERS-1:0]   mode_eff;
    logic [OPW*NUM_LAYERS-1:0] op_eff;

    logic [PIXEL_SIZE-1:0]     stage_pix   [NUM_LAYERS];
    logic [PRECISION-1:0]      stage_x     [NUM_LAYERS];
    logic [PRECISION-1:0]      stage_y     [NUM_LAYERS];
    logic [NUM_LAYERS-1:0]     stage_valid;

    // Background and coordinates wait here until layer 0's fetch catches up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FETCH_DELAY; i++) begin
                bg_dly[i] <= '0;
                x_dly[i]  <= '0;
                y_dly[i]  <= '0;
            end
            valid_dly <= '0;
        end else begin
            bg_dly[0]    <= bg_pixel_in;
            x_dly[0]     <= pixel_x;
            y_dly[0]     <= pixel_y;
            valid_dly[0] <= pixel_valid;
            for (int i = 1; i < FETCH_DELAY; i++) begin
                bg_dly[i]    <= bg_dly[i-1];
                x_dly[i]     <= x_dly[i-1];
                y_dly[i]     <= y_dly[i-1];
                valid_dly[i] <= valid_dly[i-1];
            end
        end
    end

`ifdef PIPELINE_FRAME_LATCH_EN
    logic                      frame_start;
    logic [2*NUM_LAYERS-1:0]   mode_shadow;
    logic [OPW*NUM_LAYERS-1:0] op_shadow;

    assign frame_start = pixel_valid && (pixel_x == '0) && (pixel_y == '0);

    // Controls are sampled once per frame so every stage switches together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_shadow <= '0;
            op_shadow   <= '0;
        end else if (frame_start) begin
            mode_shadow <= ctrl_layer_mode;
            op_shadow   <= ctrl_layer_opacity;
        end
    end

    assign mode_eff = mode_shadow;
    assign op_eff   = op_shadow;
`else
    assign mode_eff = ctrl_layer_mode;
    assign op_eff   = ctrl_layer_opacity;
`endif

    for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_stage
        logic [PIXEL_SIZE-1:0] fg_k;
        logic                  skip_k;
        logic [PIXEL_SIZE-1:0] acc_k;
        logic [PRECISION-1:0]  x_k;
        logic [PRECISION-1:0]  y_k;
        logic                  valid_k;
        logic [1:0]            mode_k;
        logic [OPW-1:0]        op_raw;
        logic [OPW-1:0]        op_k;
        logic                  keyed;
        logic [PIXEL_SIZE-1:0] blend_res;
        logic [PIXEL_SIZE-1:0] result;
        logic [PIXEL_SIZE-1:0] pix_q;
        logic [PRECISION-1:0]  x_q;
        logic [PRECISION-1:0]  y_q;
        logic                  valid_q;

        if (k == 0) begin : g_first
            assign fg_k    = fg_pixel_in[0 +: PIXEL_SIZE];
            assign skip_k  = fg_pixel_skip[0];
            assign acc_k   = bg_dly[FETCH_DELAY-1];
            assign x_k     = x_dly[FETCH_DELAY-1];
            assign y_k     = y_dly[FETCH_DELAY-1];
            assign valid_k = valid_dly[FETCH_DELAY-1];
        end else begin : g_next
            logic [PIXEL_SIZE-1:0] fg_dly [k];
            logic [k-1:0]          skip_dly;

            // Layer k arrives with layer 0, so it is held k cycles to meet its stage.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < k; i++) begin
                        fg_dly[i] <= '0;
                    end
                    skip_dly <= '0;
                end else begin
                    fg_dly[0]   <= fg_pixel_in[k*PIXEL_SIZE +: PIXEL_SIZE];
                    skip_dly[0] <= fg_pixel_skip[k];
                    for (int i = 1; i < k; i++) begin
                        fg_dly[i]   <= fg_dly[i-1];
                        skip_dly[i] <= skip_dly[i-1];
                    end
                end
            end

            assign fg_k    = fg_dly[k-1];
            assign skip_k  = skip_dly[k-1];
            assign acc_k   = stage_pix[k-1];
            assign x_k     = stage_x[k-1];
            assign y_k     = stage_y[k-1];
            assign valid_k = stage_valid[k-1];
        end

        assign mode_k = mode_eff[2*k +: 2];
        assign op_raw = op_eff[k*OPW +: OPW];

        always_comb begin
            op_k      = (op_raw > OPACITY_ONE) ? OPACITY_ONE : op_raw;
            keyed     = (fg_k == KEY);
            blend_res = blend_pixel(fg_k, acc_k, op_k);
            result    = acc_k;
            if (!skip_k) begin
                case (mode_k)
                    2'd1:    result = keyed ? acc_k : fg_k;
                    2'd2:    result = blend_res;
                    2'd3:    result = keyed ? acc_k : blend_res;
                    default: result = acc_k;
                endcase
            end
        end

        // Blanking slots carry all zeros so downstream never sees stale data.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pix_q   <= '0;
                x_q     <= '0;
                y_q     <= '0;
                valid_q <= 1'b0;
            end else if (valid_k) begin
                pix_q   <= result;
                x_q     <= x_k;
                y_q     <= y_k;
                valid_q <= 1'b1;
            end else begin
                pix_q   <= '0;
                x_q     <= '0;
                y_q     <= '0;
                valid_q <= 1'b0;
            end
        end

        assign stage_pix[k]   = pix_q;
        assign stage_x[k]     = x_q;
        assign stage_y[k]     = y_q;
        assign stage_valid[k] = valid_q;
    end

    assign pixel_out       = stage_pix[NUM_LAYERS-1];
    assign pixel_x_out     = stage_x[NUM_LAYERS-1];
    assign pixel_y_out     = stage_y[NUM_LAYERS-1];
    assign pixel_valid_out = stage_valid[NUM_LAYERS-1];

endmodule

// File: tb/tb_pipeline_layered_compositor.sv
// Scoreboard bench for pipeline_layered_compositor with default parameters (latency 5).
// Frame-latch expectations follow PIPELINE_FRAME_LATCH_EN.
module tb_pipeline_layered_compositor;

    typedef struct {
        logic [15:0] pix;
        logic [10:0] x;
        logic [10:0] y;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [10:0] pixel_x;
    logic [10:0] pixel_y;
    logic        pixel_valid;
    logic [15:0] bg_pixel_in;
    logic [31:0] fg_pixel_in;
    logic [1:0]  fg_pixel_skip;
    logic [3:0]  ctrl_layer_mode;
    logic [7:0]  ctrl_layer_opacity;
    logic [15:0] pixel_out;
    logic [10:0] pixel_x_out;
    logic [10:0] pixel_y_out;
    logic        pixel_valid_out;

    exp_t        sb [$];
    exp_t        mon_e;
    int          total;
    int          bad;
    int          cyc;
    int          slot;
    logic [31:0] fg_hist   [0:3];
    logic [1:0]  skip_hist [0:3];
    logic [3:0]  next_mode;
    logic [7:0]  next_op;

    pipeline_layered_compositor dut (
        .clk                (clk),
        .rst                (rst),
        .pixel_x            (pixel_x),
        .pixel_y            (pixel_y),
        .pixel_valid        (pixel_valid),
        .bg_pixel_in        (bg_pixel_in),
        .fg_pixel_in        (fg_pixel_in),
        .fg_pixel_skip      (fg_pixel_skip),
        .ctrl_layer_mode    (ctrl_layer_mode),
        .ctrl_layer_opacity (ctrl_layer_opacity),
        .pixel_out          (pixel_out),
        .pixel_x_out        (pixel_x_out),
        .pixel_y_out        (pixel_y_out),
        .pixel_valid_out    (pixel_valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
        total = total + 1;
        if (act !== expv) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // One call per clock; fg/skip are replayed three calls later to model the fetch delay.
    task automatic apply_stimulus(input logic v, input logic [10:0] x, input logic [10:0] y,
                                  input logic [15:0] bg, input logic [31:0] fg,
                                  input logic [1:0] skip, input logic [15:0] expv);
        exp_t e;
        @(negedge clk);
        pixel_valid        = v;
        pixel_x            = x;
        pixel_y            = y;
        bg_pixel_in        = bg;
        ctrl_layer_mode    = next_mode;
        ctrl_layer_opacity = next_op;
        fg_hist[slot]      = fg;
        skip_hist[slot]    = skip;
        fg_pixel_in        = fg_hist[(slot + 1) % 4];
        fg_pixel_skip      = skip_hist[(slot + 1) % 4];
        slot               = (slot + 1) % 4;
        if (v) begin
            e.pix = expv;
            e.x   = x;
            e.y   = y;
            e.due = cyc + 5;
            sb.push_back(e);
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++)
            apply_stimulus(1'b0, 11'd0, 11'd0, 16'hFFFF, 32'hFFFF_FFFF, 2'b00, 16'h0000);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (pixel_valid_out) begin
                if (sb.size() == 0) begin
                    total = total + 1;
                    bad   = bad + 1;
                    $display("[TB] FAIL unexpected_output: got pixel %h at (%0d,%0d) expected none",
                             pixel_out, pixel_x_out, pixel_y_out);
                end else begin
                    mon_e = sb.pop_front();
                    check_output("pixel_out",    {16'h0, pixel_out},   {16'h0, mon_e.pix});
                    check_output("pixel_x_out",  {21'h0, pixel_x_out}, {21'h0, mon_e.x});
                    check_output("pixel_y_out",  {21'h0, pixel_y_out}, {21'h0, mon_e.y});
                    check_output("latency_cycle", cyc, mon_e.due);
                end
            end else begin
                check_output("blank_pixel", {16'h0, pixel_out}, 32'h0);
            end
        end
    end

    initial begin
        total = 0; bad = 0; cyc = 0; slot = 0;
        for (int i = 0; i < 4; i++) begin
            fg_hist[i]   = '0;
            skip_hist[i] = '0;
        end
        rst = 1'b1;
        pixel_x = '0; pixel_y = '0; pixel_valid = 1'b0; bg_pixel_in = '0;
        fg_pixel_in = '0; fg_pixel_skip = '0;
        ctrl_layer_mode = '0; ctrl_layer_opacity = '0;
        next_mode = 4'b0000; next_op = 8'h00;

        #1;
        check_output("reset_valid", {31'h0, pixel_valid_out}, 32'h0);
        check_output("reset_pixel", {16'h0, pixel_out}, 32'h0);
        check_output("reset_x",     {21'h0, pixel_x_out}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] pass-through");
        apply_stimulus(1'b1, 11'd0, 11'd0, 16'h1234, 32'hFFFF_FFFF, 2'b00, 16'h1234);
        apply_stimulus(1'b1, 11'd1, 11'd0, 16'h1234, 32'h0000_F800, 2'b00, 16'h1234);
        apply_stimulus(1'b1, 11'd5, 11'd7, 16'hABCD, 32'h258C_258C, 2'b00, 16'hABCD);
        drain(6);

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 7; i++)
            apply_stimulus(1'b1, 11'(10 + i), 11'd3, 16'(16'h1000 + i), 32'h0, 2'b00, 16'(16'h1000 + i));
        #2 rst = 1'b1;
        #1;
        check_output("midreset_valid", {31'h0, pixel_valid_out}, 32'h0);
        check_output("midreset_pixel", {16'h0, pixel_out}, 32'h0);
        check_output("midreset_x",     {21'h0, pixel_x_out}, 32'h0);
        sb.delete();
        drain(2);
        rst = 1'b0;
        apply_stimulus(1'b1, 11'd0, 11'd0, 16'h0F0F, 32'h0, 2'b00, 16'h0F0F);
        apply_stimulus(1'b1, 11'd1, 11'd0, 16'h5555, 32'h0, 2'b00, 16'h5555);
        drain(6);

        $display("[TB] chroma key");
        next_mode = 4'b0001; next_op = 8'h00;
        apply_stimulus(1'b1, 11'd0, 11'd0, 16'h1234, 32'h0000_258C, 2'b00, 16'h1234);
        apply_stimulus(1'b1, 11'd1, 11'd0, 16'h1234, 32'h0000_FFFF, 2'b00, 16'hFFFF);
        drain(6);
        next_mode = 4'b0101;
        apply_stimulus(1'b1, 11'd0, 11'd0, 16'h1234, 32'h0001_FFFF, 2'b00, 16'h0001);
        apply_stimulus(1'b1, 11'd1, 11'd0, 16'h1234, 32'h258C_FFFF, 2'b00, 16'hFFFF);
        drain(6);

        $display("[TB] overlay");
        next_mode = 4'b0010; next_op = 8'h04;
        apply_stimulus(1'b1, 11'd0, 11'd0, 16'h001F, 32'h0000_F800, 2'b00, 16'h780F);
        apply_stimulus(1'b1, 11'd1, 11'd0, 16'h0000, 32'h0000_07E0, 2'b00, 16'h03E0);
        apply_stimulus(1'b1, 11'd2, 11'd0, 16'h001F, 32'h0000_F800, 2'b01, 16'h001F);
        apply_stimulus(1'b1, 11'd3, 11'd0, 16'h001F, 32'h0000_F800, 2'b10, 16'h780F);
        drain(6);
        next_op = 8'h08;
        apply_stimulus(1'b1, 11'd0, 11'd0, 16'h001F, 32'h0000_F800, 2'b00, 16'hF800);
        drain(6);
        next_op = 8'h0F;
        apply_stimulus(1'b1, 11'd0, 11'd0, 16'h001F, 32'h0000_F800, 2'b00, 16'hF800);
        drain(6);
        next_op = 8'h02;
        apply_stimulus(1'b1, 11'd0, 11'd0, 16'h0000, 32'h0000_07E0, 2'b00, 16'h01E0);
        drain(6);

        $display("[TB] key plus overlay");
        next_mode = 4'b0011; next_op = 8'h04;
        apply_stimulus(1'b1, 11'd0, 11'd0, 16'h001F, 32'h0000_258C, 2'b00, 16'h001F);
        apply_stimulus(1'b1, 11'd1, 11'd0, 16'h001F, 32'h0000_F800, 2'b00, 16'h780F);
        drain(6);

        $display("[TB] two layers");
        next_mode = 4'b1010; next_op = 8'h48;
        apply_stimulus(1'b1, 11'd0, 11'd0, 16'h0000, 32'h001F_F800, 2'b00, 16'h780F);
        drain(6);

        $display("[TB] frame latch");
        next_mode = 4'b0010; next_op = 8'h08;
        apply_stimulus(1'b1, 11'd0, 11'd0, 16'h0000, 32'h0000_F800, 2'b00, 16'hF800);
        apply_stimulus(1'b1, 11'd99, 11'd50, 16'h001F, 32'h0000_F800, 2'b00, 16'hF800);
        drain(3);
        next_mode = 4'b0000;
`ifdef PIPELINE_FRAME_LATCH_EN
        apply_stimulus(1'b1, 11'd100, 11'd50, 16'h001F, 32'h0000_F800, 2'b00, 16'hF800);
        apply_stimulus(1'b1, 11'd101, 11'd50, 16'h001F, 32'h0000_F800, 2'b00, 16'hF800);
`else
        apply_stimulus(1'b1, 11'd100, 11'd50, 16'h001F, 32'h0000_F800, 2'b00, 16'h001F);
        apply_stimulus(1'b1, 11'd101, 11'd50, 16'h001F, 32'h0000_F800, 2'b00, 16'h001F);
`endif
        drain(6);
        apply_stimulus(1'b1, 11'd0, 11'd0, 16'h001F, 32'h0000_F800, 2'b00, 16'h001F);
        apply_stimulus(1'b1, 11'd1, 11'd0, 16'h001F, 32'h0000_F800, 2'b00, 16'h001F);
        drain(8);

        check_output("scoreboard_empty", sb.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_layered_compositor.md
# pipeline_layered_compositor

Parametrised successor to the single-foreground compositing pipeline. It merges a background pixel stream with NUM_LAYERS foreground layers, one registered blend stage per layer, each with its own mode and opacity. Per-layer control can be latched at frame start so changes never tear mid-frame. It sits between the background/foreground fetch logic (SRAM readers) and the VGA output stage.

## Interface
- R_WIDTH, 5, red bits; G_WIDTH, 6, green bits; B_WIDTH, 5, blue bits (PIXEL_SIZE = sum)
- RED_PASS / GREEN_PASS / BLUE_PASS, 5'b00100 / 6'b101100 / 5'b01100, chroma key colour
- PRECISION, 11, coordinate width
- FETCH_DELAY, 3, cycles (≥1) from pixel_x/pixel_y to the matching layer-0 fg_pixel_in
- NUM_LAYERS, 2, foreground layers (1..4)
- TRANSPARENCY_PRECISION, 3, opacity fraction bits (T)

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- pixel_x, pixel_y  in  PRECISION  coordinate of the incoming background pixel
- pixel_valid  in  1  high = active video, low = blanking
- bg_pixel_in  in  PIXEL_SIZE  background pixel, same cycle as pixel_x
- fg_pixel_in  in  NUM_LAYERS*PIXEL_SIZE  layer k at slice k, arrives FETCH_DELAY cycles after its coordinate
- fg_pixel_skip  in  NUM_LAYERS  bit k = layer k has no valid pixel this cycle
- ctrl_layer_mode  in  2*NUM_LAYERS  per layer: 0 off, 1 chroma key, 2 overlay, 3 chroma key + overlay
- ctrl_layer_opacity  in  (T+1)*NUM_LAYERS  per-layer opacity, 0..2^T
- pixel_out  out  PIXEL_SIZE  composited pixel
- pixel_x_out, pixel_y_out  out  PRECISION  coordinate of pixel_out
- pixel_valid_out  out  1  delayed pixel_valid

## Operation
- Alignment: bg_pixel_in, pixel_x, pixel_y and pixel_valid pass through a FETCH_DELAY-deep register delay line, then enter stage 0 alongside fg layer 0.
- Stage k (0..NUM_LAYERS-1) registers the blend of layer k onto stage k-1's result (stage 0 uses the aligned bg). fg slice k and skip bit k are internally delayed k cycles to meet stage k. Coordinates and valid ride alongside.
- Per-stage blend per channel, where acc is the incoming result, fg the layer pixel and op the opacity:
  - mode 0, or skip = 1: acc passes unchanged.
  - mode 1: fg, unless fg equals the key exactly, then acc.
  - mode 2: (fg*op + acc*(2^T − op)) >> T. op values above 2^T saturate to 2^T. Intermediates are computed at channel width + T + 1 bits, with no overflow.
  - mode 3: keyed pixels yield acc; other pixels use the mode-2 formula.
- Blanking: when the valid travelling with a stage is low, that stage outputs all zeros.
- Reset: all delay lines, stage registers and outputs go to 0, including pixel_valid_out. Shadowed controls reset to mode 0 and opacity 0. Reset mid-frame discards in-flight pixels; the first valid output follows the next valid input after the full latency.

## Timing
- Latency: FETCH_DELAY + NUM_LAYERS cycles from pixel_x/bg_pixel_in to pixel_out; throughput is one pixel per cycle.
- Example: FETCH_DELAY = 3, NUM_LAYERS = 2 gives 5 cycles.
- No backpressure. Inputs are sampled every cycle.
- Frame start is the input cycle with pixel_valid = 1 and pixel_x = pixel_y = 0.
- With latching enabled, the new control set takes effect on the cycle after frame start, in every stage at once. Pixels still in flight from the previous frame are blanking, so nothing visible tears.

## Configuration
- PIPELINE_FRAME_LATCH_EN defined: ctrl_layer_mode and ctrl_layer_opacity are captured into shadow registers only at frame start; mid-frame changes are ignored until the next frame.
- Not defined: stages use the ctrl inputs directly every cycle, with no shadow registers. Reset values apply only to the data path.

## Test plan
- Reset: assert rst mid-stream → all outputs 0 immediately. Release and feed valid pixels → first pixel_valid_out exactly 5 cycles later (defaults).
- Pass-through: all modes 0, bg 16'h1234 → pixel_out 16'h1234 after 5 cycles, with matching x/y.
- Chroma: layer 0 mode 1, fg = key colour → bg out. fg = 16'hFFFF → 16'hFFFF. Layer 1 mode 1 with fg 16'h0001 overrides → 16'h0001.
- Overlay: layer 0 mode 2, op 4 (T = 3), fg R = 31, bg R = 0 → R = 15. op 8 → R = 31. op 15 → saturates to R = 31. skip = 1 → bg.
- Blanking: pixel_valid low with bg 16'hFFFF → pixel_out 0 and pixel_valid_out 0.
- Frame latch (macro on): change layer 0 mode 2→0 at pixel (100,50) → output unchanged for the rest of that frame, switches from frame-start pixel (0,0) of the next frame. With the macro off → the change appears 5 cycles after the write.
